// File: rtl/blink_pkg.sv
// Shared types and sizing helpers for the blink driver.
// The pending-request queue is enabled by defining BLINK_DRIVER_QUEUE_EN.
package blink_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } blink_state_t;

  // Phase counter must hold max(on, off) - 1; sized with headroom for the max itself.
  function automatic int cnt_width(input int on_cycles, input int off_cycles);
    int longest;
    longest = (on_cycles > off_cycles) ? on_cycles : off_cycles;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/blink_timer.sv
// Loadable down-counter: load takes priority, otherwise counts down and holds at 0.
// done is high while the count is 0.
module blink_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/blink_driver.sv
// Pulse stretcher: each request produces an ON_CYCLES blink followed by an OFF_CYCLES gap.
// BLINK_DRIVER_QUEUE_EN queues extra requests; without it, ON retriggers and GAP drops.
module blink_driver
  import blink_pkg::*;
#(
  parameter int ON_CYCLES   = 25_000_000,
  parameter int OFF_CYCLES  = 12_500_000,
  parameter int QUEUE_DEPTH = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic pulse_in,
  output logic led_out,
  output logic busy_out,
  output logic dropped_out
);

  localparam int CW = cnt_width(ON_CYCLES, OFF_CYCLES);
  localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] OFF_LOAD = CW'(OFF_CYCLES - 1);

  blink_state_t   state;
  blink_state_t   state_next;
  logic           tmr_load;
  logic [CW-1:0]  tmr_value;
  logic           tmr_done;
  logic           drop_next;

  blink_timer #(
    .WIDTH (CW)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (tmr_load),
    .load_value (tmr_value),
    .done       (tmr_done)
  );

`ifdef BLINK_DRIVER_QUEUE_EN
  localparam int PW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [PW-1:0] DEPTH = PW'(QUEUE_DEPTH);

  logic [PW-1:0] pending;
  logic [PW-1:0] pending_next;
  logic [PW:0]   eff;

  always_comb begin
    state_next   = state;
    pending_next = pending;
    tmr_load     = 1'b0;
    tmr_value    = ON_LOAD;
    drop_next    = 1'b0;
    // A request arriving on the GAP-end edge joins the backlog before the decrement.
    eff          = {1'b0, pending} + {{PW{1'b0}}, pulse_in};
    case (state)
      IDLE: begin
        if (pulse_in) begin
          state_next = ON;
          tmr_load   = 1'b1;
          tmr_value  = ON_LOAD;
        end
      end
      ON: begin
        if (pulse_in) begin
          if (pending < DEPTH) pending_next = pending + 1'b1;
          else                 drop_next    = 1'b1;
        end
        if (tmr_done) begin
          state_next = GAP;
          tmr_load   = 1'b1;
          tmr_value  = OFF_LOAD;
        end
      end
      GAP: begin
        if (tmr_done) begin
          if (eff != '0) begin
            state_next   = ON;
            tmr_load     = 1'b1;
            tmr_value    = ON_LOAD;
            pending_next = PW'(eff - 1'b1);
          end else begin
            state_next = IDLE;
          end
        end else if (pulse_in) begin
          if (pending < DEPTH) pending_next = pending + 1'b1;
          else                 drop_next    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= pending_next;
  end
`else
  always_comb begin
    state_next = state;
    tmr_load   = 1'b0;
    tmr_value  = ON_LOAD;
    drop_next  = 1'b0;
    case (state)
      IDLE: begin
        if (pulse_in) begin
          state_next = ON;
          tmr_load   = 1'b1;
          tmr_value  = ON_LOAD;
        end
      end
      ON: begin
        // A request during ON restarts the full ON period, even on its last cycle.
        if (pulse_in) begin
          tmr_load  = 1'b1;
          tmr_value = ON_LOAD;
        end else if (tmr_done) begin
          state_next = GAP;
          tmr_load   = 1'b1;
          tmr_value  = OFF_LOAD;
        end
      end
      GAP: begin
        drop_next = pulse_in;
        if (tmr_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end
`endif

  // Outputs are registered copies of the next-state decode, so they change with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      led_out     <= 1'b0;
      busy_out    <= 1'b0;
      dropped_out <= 1'b0;
    end else begin
      state       <= state_next;
      led_out     <= (state_next == ON);
      busy_out    <= (state_next != IDLE);
      dropped_out <= drop_next;
    end
  end

endmodule

// File: tb/tb_blink_driver.sv
// Directed bench for blink_driver (ON=4, OFF=2, DEPTH=2); expectations follow BLINK_DRIVER_QUEUE_EN.
// Vector bit k: pulse_in during the cycle sampled by edge k+1; outputs as seen after edge k.
`timescale 1ns/1ps
module tb_blink_driver;

  localparam int ON_C  = 4;
  localparam int OFF_C = 2;
  localparam int QD    = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pulse_in = 1'b0;
  logic led_out;
  logic busy_out;
  logic dropped_out;

  logic [2:0] exp_q[$];
  int         tag_q[$];
  string      cur_name = "init";
  int         n_checks = 0;
  int         n_pass = 0;

  blink_driver #(
    .ON_CYCLES   (ON_C),
    .OFF_CYCLES  (OFF_C),
    .QUEUE_DEPTH (QD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pulse_in    (pulse_in),
    .led_out     (led_out),
    .busy_out    (busy_out),
    .dropped_out (dropped_out)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic check_bit(input string name, input int cyc, input logic got, input logic want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s edge %0d: got %b, expected %b", name, cyc, got, want);
  endtask

  task automatic check_idle_now(input string name);
    check_bit({name, " led_out"},     -1, led_out,     1'b0);
    check_bit({name, " busy_out"},    -1, busy_out,    1'b0);
    check_bit({name, " dropped_out"}, -1, dropped_out, 1'b0);
  endtask

  // Scoreboard monitor: one expected {led, busy, drop} triple per cycle, checked mid-cycle.
  always @(negedge clk) begin : monitor
    logic [2:0] e;
    int         t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_bit({cur_name, " led_out"},     t, led_out,     e[2]);
      check_bit({cur_name, " busy_out"},    t, busy_out,    e[1]);
      check_bit({cur_name, " dropped_out"}, t, dropped_out, e[0]);
    end
  end

  // Driver: called just after an edge; pushes the expectation for that edge, then drives.
  task automatic run_vec(input string name, input int n, input logic [31:0] pv,
                         input logic [31:0] lv, input logic [31:0] bv, input logic [31:0] dv);
    cur_name = name;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back({lv[k], bv[k], dv[k]});
      tag_q.push_back(k);
      pulse_in = pv[k];
      @(posedge clk);
      #1;
    end
    pulse_in = 1'b0;
  endtask

  task automatic reset_mid_on(input string name);
    // Three back-to-back requests, then reset during the first blink's ON phase.
    run_vec({name, " setup"}, 4, 32'h7, 32'hE, 32'hE, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    check_idle_now({name, " async"});
    @(posedge clk);
    #1;
    check_idle_now({name, " held"});
    rst = 1'b0;
    run_vec({name, " after"}, 16, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    #1;
    rst = 1'b1;
    #2;
    check_idle_now("reset before clock");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Request on the first edge after reset release, single blink
    run_vec("single", 9, 32'h1, 32'h1E, 32'h7E, 32'h0);

`ifdef BLINK_DRIVER_QUEUE_EN
    run_vec("queue three plus drop", 21, 32'h1D, 32'h1E79E, 32'h7FFFE, 32'h20);
    run_vec("pulse at gap end pending1", 21, 32'h45, 32'h1E79E, 32'h7FFFE, 32'h0);
    run_vec("pulse at gap end pending0", 15, 32'h41, 32'h79E, 32'h1FFE, 32'h0);
    run_vec("held pulse four", 21, 32'hF, 32'h1E79E, 32'h7FFFE, 32'h10);
`else
    run_vec("retrigger", 12, 32'h9, 32'hFE, 32'h3FE, 32'h0);
    run_vec("retrigger last on", 13, 32'h11, 32'h1FE, 32'h7FE, 32'h0);
    run_vec("drop in gap", 10, 32'h21, 32'h1E, 32'h7E, 32'h40);
    run_vec("drop at gap end", 10, 32'h41, 32'h1E, 32'h7E, 32'h80);
    run_vec("held pulse three", 11, 32'h7, 32'h7E, 32'h1FE, 32'h0);
`endif

    reset_mid_on("reset mid on");
    run_vec("single after reset", 9, 32'h1, 32'h1E, 32'h7E, 32'h0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
